// File: rtl/dcm_ctrl_pkg.sv
// ============================================================================
// Module  : dcm_ctrl_pkg
// Purpose : Shared types, code limits and the step helper for dcm_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dcm_ctrl_pkg;

  localparam int                   PROG_W   = 3;
  localparam logic [PROG_W-1:0]    PROG_MAX = 3'd7;
  localparam logic [PROG_W-1:0]    PROG_MIN = 3'd0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_EDGE = 3'd2,
    PULSE     = 3'd3,
    SETTLE    = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Saturating one-step move of a divide code.
  function automatic logic [PROG_W-1:0] step_code(input logic [PROG_W-1:0] cur,
                                                  input logic              up);
    if (up) return (cur == PROG_MAX) ? PROG_MAX : cur + 3'd1;
    else    return (cur == PROG_MIN) ? PROG_MIN : cur - 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcm_ctrl_edge_sync.sv
// ============================================================================
// Module  : dcm_ctrl_edge_sync
// Purpose : Two-flop synchronizer with a rising-edge pulse on the synced level.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dcm_ctrl_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/dcm_ctrl.sv
// ============================================================================
// Module  : dcm_ctrl
// Purpose : Reconfiguration sequencer for the programmable clock divider.
//           Optional DCM_CTRL_EDGE_SYNC_EN aligns update to a clk_2_fb edge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dcm_ctrl
  import dcm_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        req_prog,
  input  logic              step_up,
  input  logic              step_down,
  input  logic              clk_2_fb,
  output logic [2:0]        prog_out,
  output logic              update,
  output logic              busy,
  output logic              ack,
  output logic              sat,
  output logic [2:0]        cur_prog
);

  localparam logic [7:0] C_SETTLE_INIT = 8'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [PROG_W-1:0]   target_q, target_d;
  logic [PROG_W-1:0]   prog_out_q, prog_out_d;
  logic [PROG_W-1:0]   cur_prog_q, cur_prog_d;
  logic [7:0]          settle_q, settle_d;
  logic                sat_q, sat_d;

`ifdef DCM_CTRL_EDGE_SYNC_EN
  localparam logic [15:0] C_TIMEOUT_INIT = 16'(TIMEOUT_CYC - 1);

  logic        edge_rise;
  logic [15:0] timeout_q, timeout_d;

  dcm_ctrl_edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (clk_2_fb),
    .rise (edge_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 16'd0;
    else     timeout_q <= timeout_d;
  end
`else
  // Feedback clock and timeout only matter with edge alignment enabled.
  logic unused_edge_cfg;
  assign unused_edge_cfg = clk_2_fb ^ (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    prog_out_d = prog_out_q;
    settle_d   = settle_q;
    sat_d      = 1'b0;
`ifdef DCM_CTRL_EDGE_SYNC_EN
    timeout_d  = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          target_d = req_prog;
          state_d  = LOAD;
        end else if (step_up ^ step_down) begin
          target_d = step_code(cur_prog_q, step_up);
          // A clamped step acknowledges immediately without touching the divider.
          if (target_d == cur_prog_q) begin
            sat_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        prog_out_d = target_q;
`ifdef DCM_CTRL_EDGE_SYNC_EN
        timeout_d  = C_TIMEOUT_INIT;
        state_d    = WAIT_EDGE;
`else
        state_d    = PULSE;
`endif
      end

`ifdef DCM_CTRL_EDGE_SYNC_EN
      WAIT_EDGE: begin
        if (edge_rise || (timeout_q == 16'd0)) state_d = PULSE;
        else                                   timeout_d = timeout_q - 16'd1;
      end
`endif

      PULSE: begin
        settle_d = C_SETTLE_INIT;
        state_d  = SETTLE;
      end

      SETTLE: begin
        if (settle_q == 8'd0) state_d  = DONE;
        else                  settle_d = settle_q - 8'd1;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Commit lands on the edge entering DONE so cur_prog and ack move together.
    cur_prog_d = (state_d == DONE) ? target_d : cur_prog_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      prog_out_q <= '0;
      cur_prog_q <= '0;
      settle_q   <= 8'd0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      prog_out_q <= prog_out_d;
      cur_prog_q <= cur_prog_d;
      settle_q   <= settle_d;
      sat_q      <= sat_d;
    end
  end

  assign prog_out = prog_out_q;
  assign cur_prog = cur_prog_q;
  assign update   = (state_q == PULSE);
  assign busy     = (state_q != IDLE);
  assign ack      = (state_q == DONE);
  assign sat      = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_dcm_ctrl.sv
// ============================================================================
// Module  : tb_dcm_ctrl
// Purpose : Directed self-checking bench for dcm_ctrl (default build).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [2:0] req_prog = 3'd0;
  logic       step_up = 1'b0;
  logic       step_down = 1'b0;
  logic       clk_2_fb = 1'b0;
  logic [2:0] prog_out;
  logic       update, busy, ack, sat;
  logic [2:0] cur_prog;

  int n_tests = 0;
  int n_fail  = 0;

  dcm_ctrl #(.SETTLE_CYC(4), .TIMEOUT_CYC(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_prog  (req_prog),
    .step_up   (step_up),
    .step_down (step_down),
    .clk_2_fb  (clk_2_fb),
    .prog_out  (prog_out),
    .update    (update),
    .busy      (busy),
    .ack       (ack),
    .sat       (sat),
    .cur_prog  (cur_prog)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs from the accept cycle to the ack cycle, then one more cycle back to IDLE.
  task automatic wait_ack(output int cyc, output int upd, output int sat_seen,
                          output int cur_at_ack, output int busy_after);
    bit got;
    got = 0; cyc = 0; upd = 0; sat_seen = 0; cur_at_ack = -1; busy_after = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      step_up   = 1'b0;
      step_down = 1'b0;
      cyc++;
      if (update) upd++;
      if (ack) begin
        got        = 1;
        sat_seen   = int'(sat);
        cur_at_ack = int'(cur_prog);
        req        = 1'b0;
        break;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    tick();
    busy_after = int'(busy);
  endtask

  int cyc, upd, sv, cv, bv, acc;

  initial begin
    // Reset state
    #2;
    chk("reset_outputs", int'({prog_out, update, busy, ack, sat, cur_prog}), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Host request to code 6, cycle by cycle
    req = 1'b1; req_prog = 3'd6;
    chk("idle_not_busy", int'(busy), 0);
    tick();
    chk("load_busy", int'(busy), 1);
    chk("load_no_update", int'(update), 0);
    tick();
    chk("pulse_update", int'(update), 1);
    chk("pulse_prog_out", int'(prog_out), 6);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc = acc | int'({update, ack});
      if (cur_prog != 3'd0) acc = acc | 4;
    end
    chk("settle_quiet", acc, 0);
    tick();
    chk("done_ack", int'(ack), 1);
    chk("done_cur_prog", int'(cur_prog), 6);
    chk("done_busy_sat", int'({busy, sat}), 2);
    req = 1'b0;
    tick();
    chk("back_idle", int'({busy, ack, update}), 0);

    // Step up 6 -> 7: full sequence
    step_up = 1'b1;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("step_up_latency", cyc, 7);
    chk("step_up_updates", upd, 1);
    chk("step_up_cur", cv, 7);
    chk("step_up_sat", sv, 0);

    // Step up at 7 saturates
    step_up = 1'b1;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("sat_up_latency", cyc, 1);
    chk("sat_up_updates", upd, 0);
    chk("sat_up_flag", sv, 1);
    chk("sat_up_cur", cv, 7);
    chk("sat_up_prog_out", int'(prog_out), 7);

    // Request 0, then step down at 0 saturates
    req = 1'b1; req_prog = 3'd0;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("req0_cur", cv, 0);
    step_down = 1'b1;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("sat_dn_latency", cyc, 1);
    chk("sat_dn_flag_upd", sv * 2 + upd, 2);
    chk("sat_dn_cur", cv, 0);

    // Simultaneous up and down at code 3 are ignored
    req = 1'b1; req_prog = 3'd3;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("req3_cur", cv, 3);
    step_up = 1'b1; step_down = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      step_up = 1'b0; step_down = 1'b0;
      acc = acc | int'({ack, update, busy});
    end
    chk("both_steps_ignored", acc, 0);
    chk("both_steps_cur", int'(cur_prog), 3);

    // req wins over step_up
    req = 1'b1; req_prog = 3'd1; step_up = 1'b1;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("req_over_step_cur", cv, 1);
    chk("req_over_step_idle", bv, 0);
    tick(); tick();
    chk("req_over_step_final", int'({busy, cur_prog}), 1);

    // Steps and req_prog changes while busy are dropped
    req = 1'b1; req_prog = 3'd5;
    tick();
    req_prog = 3'd2; step_up = 1'b1;
    tick();
    step_up = 1'b0; step_down = 1'b1;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("busy_drop_latency", cyc + 2, 7);
    chk("busy_drop_cur", cv, 5);
    tick(); tick();
    chk("busy_drop_final", int'({busy, cur_prog}), 5);

    // Reset mid-SETTLE with a same-code request (target 5)
    req = 1'b1; req_prog = 3'd5;
    tick(); tick(); tick();
    chk("pre_reset_busy", int'(busy), 1);
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({prog_out, update, busy, ack, sat, cur_prog}), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle", int'({busy, cur_prog}), 0);
    req = 1'b1; req_prog = 3'd3;
    wait_ack(cyc, upd, sv, cv, bv);
    chk("post_reset_latency", cyc, 7);
    chk("post_reset_cur", cv, 3);
    chk("post_reset_prog_out", int'(prog_out), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
